// File: rtl/rv32i_alu_mc.sv
// Purpose: RV32I ALU driven by a one-hot op vector. Shifts run serially, one bit per cycle.
// Latency: 1 cycle for all non-shift ops and for shift-by-0; n+1 cycles for a shift by n.
// Backpressure: start_i is ignored (not queued) while busy_o is high; done_o pulses once per result.
//
// Ports:
//   clk_i, rst_i           clock (rising edge) and asynchronous active-high reset
//   start_i                accept operands and op vector (in IDLE or DONE only)
//   op_*_i                 one-hot op select; first set op in port order wins
//   op_rs2_imm_i           operand B source: 1 = imm_i, 0 = rs2_i
//   rs1_i, rs2_i, imm_i    operands
//   busy_o                 serial shift in progress
//   done_o                 one-cycle pulse, result_o/br_taken_o valid
//   result_o, br_taken_o   held until the next accepted op completes
module rv32i_alu_mc #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            op_add_i,
    input  logic            op_sub_i,
    input  logic            op_sll_i,
    input  logic            op_slt_i,
    input  logic            op_sltu_i,
    input  logic            op_xor_i,
    input  logic            op_srl_i,
    input  logic            op_sra_i,
    input  logic            op_or_i,
    input  logic            op_and_i,
    input  logic            op_beq_i,
    input  logic            op_bne_i,
    input  logic            op_blt_i,
    input  logic            op_bge_i,
    input  logic            op_bltu_i,
    input  logic            op_bgeu_i,
    input  logic            op_rs2_imm_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [XLEN-1:0] imm_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic            br_taken_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [1:0] SH_SLL = 2'd0;
    localparam logic [1:0] SH_SRL = 2'd1;
    localparam logic [1:0] SH_SRA = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0] work_q, work_d;
    logic [1:0]      kind_q, kind_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            br_q, br_d;

    logic [XLEN-1:0] opb;
    logic [SHW-1:0]  amt;
    logic [XLEN-1:0] res_c;
    logic            br_c;
    logic            is_shift_c;
    logic [1:0]      kind_c;
    logic [XLEN-1:0] work_shifted;
    logic            accept;

    assign opb    = op_rs2_imm_i ? imm_i : rs2_i;
    assign amt    = opb[SHW-1:0];
    assign accept = start_i && (state_q != S_SHIFT);

    // Priority chain in port order gives the "first set op wins" rule for
    // malformed multi-hot vectors. A shift selected here only goes serial when
    // its amount is nonzero; a zero-amount shift returns A in one cycle.
    always_comb begin
        res_c      = '0;
        br_c       = 1'b0;
        is_shift_c = 1'b0;
        kind_c     = SH_SLL;
        if (op_add_i) begin
            res_c = rs1_i + opb;
        end else if (op_sub_i) begin
            res_c = rs1_i - opb;
        end else if (op_sll_i) begin
            res_c      = rs1_i;
            is_shift_c = 1'b1;
            kind_c     = SH_SLL;
        end else if (op_slt_i) begin
            res_c = {{(XLEN-1){1'b0}}, ($signed(rs1_i) < $signed(opb))};
        end else if (op_sltu_i) begin
            res_c = {{(XLEN-1){1'b0}}, (rs1_i < opb)};
        end else if (op_xor_i) begin
            res_c = rs1_i ^ opb;
        end else if (op_srl_i) begin
            res_c      = rs1_i;
            is_shift_c = 1'b1;
            kind_c     = SH_SRL;
        end else if (op_sra_i) begin
            res_c      = rs1_i;
            is_shift_c = 1'b1;
            kind_c     = SH_SRA;
        end else if (op_or_i) begin
            res_c = rs1_i | opb;
        end else if (op_and_i) begin
            res_c = rs1_i & opb;
        end else if (op_beq_i) begin
            br_c = (rs1_i == opb);
        end else if (op_bne_i) begin
            br_c = (rs1_i != opb);
        end else if (op_blt_i) begin
            br_c = ($signed(rs1_i) < $signed(opb));
        end else if (op_bge_i) begin
            br_c = ($signed(rs1_i) >= $signed(opb));
        end else if (op_bltu_i) begin
            br_c = (rs1_i < opb);
        end else if (op_bgeu_i) begin
            br_c = (rs1_i >= opb);
        end
    end

    // One-bit step of the serial shifter.
    always_comb begin
        work_shifted = {work_q[XLEN-2:0], 1'b0};
        case (kind_q)
            SH_SRL:  work_shifted = {1'b0, work_q[XLEN-1:1]};
            SH_SRA:  work_shifted = {work_q[XLEN-1], work_q[XLEN-1:1]};
            default: work_shifted = {work_q[XLEN-2:0], 1'b0};
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        kind_d   = kind_q;
        result_d = result_q;
        br_d     = br_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    if (is_shift_c && (amt != '0)) begin
                        state_d = S_SHIFT;
                        cnt_d   = amt;
                        work_d  = rs1_i;
                        kind_d  = kind_c;
                    end else begin
                        state_d  = S_DONE;
                        result_d = res_c;
                        br_d     = br_c;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                work_d = work_shifted;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == {{(SHW-1){1'b0}}, 1'b1}) begin
                    state_d  = S_DONE;
                    result_d = work_shifted;
                    br_d     = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            work_q   <= '0;
            kind_q   <= SH_SLL;
            result_q <= '0;
            br_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            kind_q   <= kind_d;
            result_q <= result_d;
            br_q     <= br_d;
        end
    end

    assign busy_o     = (state_q == S_SHIFT);
    assign done_o     = (state_q == S_DONE);
    assign result_o   = result_q;
    assign br_taken_o = br_q;

endmodule

// File: tb/tb_rv32i_alu_mc.sv
// Self-checking bench for rv32i_alu_mc: directed scenarios plus randomized
// op vectors checked against a behavioural model of the ALU rules.
module tb_rv32i_alu_mc;

    // Op vector bit positions follow the DUT port order (add = bit 0).
    localparam int OP_ADD = 0, OP_SUB = 1, OP_SLL = 2, OP_SLT = 3, OP_SLTU = 4,
                   OP_XOR = 5, OP_SRL = 6, OP_SRA = 7, OP_OR = 8, OP_AND = 9,
                   OP_BEQ = 10, OP_BNE = 11, OP_BLT = 12, OP_BGE = 13,
                   OP_BLTU = 14, OP_BGEU = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] ops = '0;
    logic        use_imm = 1'b0;
    logic [31:0] rs1 = '0, rs2 = '0, imm = '0;
    logic        busy, done, br;
    logic [31:0] result;

    int nvec = 0;
    int nerr = 0;
    logic [31:0] exp_prev = '0;
    logic        exp_prev_br = 1'b0;

    always #5 clk = ~clk;

    rv32i_alu_mc dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .op_add_i(ops[OP_ADD]), .op_sub_i(ops[OP_SUB]), .op_sll_i(ops[OP_SLL]),
        .op_slt_i(ops[OP_SLT]), .op_sltu_i(ops[OP_SLTU]), .op_xor_i(ops[OP_XOR]),
        .op_srl_i(ops[OP_SRL]), .op_sra_i(ops[OP_SRA]), .op_or_i(ops[OP_OR]),
        .op_and_i(ops[OP_AND]), .op_beq_i(ops[OP_BEQ]), .op_bne_i(ops[OP_BNE]),
        .op_blt_i(ops[OP_BLT]), .op_bge_i(ops[OP_BGE]), .op_bltu_i(ops[OP_BLTU]),
        .op_bgeu_i(ops[OP_BGEU]), .op_rs2_imm_i(use_imm),
        .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm),
        .busy_o(busy), .done_o(done), .result_o(result), .br_taken_o(br)
    );

    // ---------------- reference model ----------------
    function automatic int winner(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Returns {br_taken, result}.
    function automatic logic [32:0] model(input logic [15:0] v, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        t;
        int          sh;
        r  = 32'd0;
        t  = 1'b0;
        sh = int'(b % 32);
        case (winner(v))
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SLL:  r = a << sh;
            OP_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            OP_XOR:  r = a ^ b;
            OP_SRL:  r = a >> sh;
            OP_SRA:  r = $signed(a) >>> sh;
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            OP_BEQ:  t = (a == b);
            OP_BNE:  t = (a != b);
            OP_BLT:  t = ($signed(a) < $signed(b));
            OP_BGE:  t = ($signed(a) >= $signed(b));
            OP_BLTU: t = (a < b);
            OP_BGEU: t = (a >= b);
            default: ;
        endcase
        return {t, r};
    endfunction

    function automatic int latency(input logic [15:0] v, input logic [31:0] b);
        int w;
        w = winner(v);
        if ((w == OP_SLL || w == OP_SRL || w == OP_SRA) && (b % 32) != 0)
            return int'(b % 32) + 1;
        return 1;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [15:0] v, input logic [31:0] a, input logic [31:0] r2,
                         input logic [31:0] im, input logic ui);
        ops = v; rs1 = a; rs2 = r2; imm = im; use_imm = ui; start = 1'b1;
    endtask

    // Issue one op at the current negedge and follow it to completion.
    task automatic run_one(input string name, input logic [15:0] v, input logic [31:0] a,
                           input logic [31:0] r2, input logic [31:0] im, input logic ui);
        logic [31:0] b;
        logic [32:0] e;
        int          lat;
        b   = ui ? im : r2;
        e   = model(v, a, b);
        lat = latency(v, b);
        drive(v, a, r2, im, ui);
        for (int cyc = 1; cyc <= lat; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            if (cyc < lat) begin
                nvec++;
                if (done !== 1'b0 || busy !== 1'b1 || result !== exp_prev || br !== exp_prev_br) begin
                    nerr++;
                    $display("FAIL %s cyc%0d in-flight: done=%b busy=%b res=%h br=%b, want done=0 busy=1 res=%h br=%b",
                             name, cyc, done, busy, result, br, exp_prev, exp_prev_br);
                end
            end else begin
                nvec++;
                if (done !== 1'b1 || busy !== 1'b0 || result !== e[31:0] || br !== e[32]) begin
                    nerr++;
                    $display("FAIL %s cyc%0d complete: done=%b busy=%b res=%h br=%b, want done=1 busy=0 res=%h br=%b",
                             name, cyc, done, busy, result, br, e[31:0], e[32]);
                end
            end
        end
        exp_prev    = e[31:0];
        exp_prev_br = e[32];
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst = 1'b1; start = 1'b0;
        #2;
        nvec++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || br !== 1'b0) begin
            nerr++;
            $display("FAIL reset_state: busy=%b done=%b res=%h br=%b, want all 0", busy, done, result, br);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        exp_prev = '0; exp_prev_br = 1'b0;
    endtask

    task automatic test_reset_mid_shift;
        run_one("pre_add", 16'(1 << OP_ADD), 32'd7, 32'd8, 32'd0, 1'b0);
        drive(16'(1 << OP_SRA), 32'h8000_0000, 32'd31, 32'd0, 1'b0);
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        nvec++;
        if (busy !== 1'b1) begin
            nerr++;
            $display("FAIL mid_shift_busy: busy=%b want 1", busy);
        end
        #2 rst = 1'b1;
        #1;
        nvec++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            nerr++;
            $display("FAIL async_reset: busy=%b done=%b res=%h, want 0 0 0", busy, done, result);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_prev = '0; exp_prev_br = 1'b0;
        run_one("post_reset_add", 16'(1 << OP_ADD), 32'd2, 32'd3, 32'd0, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [15:0] v [4];
        logic [31:0] a [4];
        logic [31:0] b [4];
        logic [31:0] e [4];
        v[0] = 16'(1 << OP_ADD);  a[0] = 32'hFFFF_FFFF; b[0] = 32'd1; e[0] = 32'h0;
        v[1] = 16'(1 << OP_SUB);  a[1] = 32'h0;         b[1] = 32'd1; e[1] = 32'hFFFF_FFFF;
        v[2] = 16'(1 << OP_SLT);  a[2] = 32'hFFFF_FFFF; b[2] = 32'd1; e[2] = 32'd1;
        v[3] = 16'(1 << OP_SLTU); a[3] = 32'hFFFF_FFFF; b[3] = 32'd1; e[3] = 32'd0;
        @(negedge clk);
        drive(v[0], a[0], b[0], 32'd0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            nvec++;
            if (done !== 1'b1 || result !== e[i-1] || br !== 1'b0) begin
                nerr++;
                $display("FAIL b2b_%0d: done=%b res=%h br=%b, want done=1 res=%h br=0", i-1, done, result, br, e[i-1]);
            end
            if (i < 4) drive(v[i], a[i], b[i], 32'd0, 1'b0);
            else start = 1'b0;
        end
        @(negedge clk);
        nvec++;
        if (done !== 1'b0) begin
            nerr++;
            $display("FAIL b2b_tail: done=%b want 0", done);
        end
        exp_prev = e[3]; exp_prev_br = 1'b0;
    endtask

    task automatic test_shifts;
        run_one("sll_31",  16'(1 << OP_SLL), 32'h1,         32'd31,   32'd0, 1'b0);
        run_one("sra_4",   16'(1 << OP_SRA), 32'h8000_0000, 32'd4,    32'd0, 1'b0);
        run_one("srl_4",   16'(1 << OP_SRL), 32'h8000_0000, 32'd4,    32'd0, 1'b0);
        run_one("sll_0",   16'(1 << OP_SLL), 32'hDEAD_BEEF, 32'h20,   32'd0, 1'b0);
        run_one("sra_imm", 16'(1 << OP_SRA), 32'h8765_4321, 32'd0,    32'hFFFF_FFE7, 1'b1);
    endtask

    task automatic test_start_during_busy;
        @(negedge clk);
        drive(16'(1 << OP_SRL), 32'h8000_0000, 32'd10, 32'd0, 1'b0);
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge clk);
            if (cyc == 1 || cyc == 4) start = 1'b0;
            nvec++;
            if (cyc == 11) begin
                if (done !== 1'b1 || result !== 32'h0020_0000) begin
                    nerr++;
                    $display("FAIL busy_ignore_done: done=%b res=%h, want done=1 res=00200000", done, result);
                end
            end else if (done !== 1'b0) begin
                nerr++;
                $display("FAIL busy_ignore_cyc%0d: done=%b want 0", cyc, done);
            end
            if (cyc == 3) drive(16'(1 << OP_ADD), 32'd1, 32'd1, 32'd0, 1'b0);
        end
        exp_prev = 32'h0020_0000; exp_prev_br = 1'b0;
    endtask

    task automatic test_branches;
        run_one("blt",  16'(1 << OP_BLT),  32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        run_one("bltu", 16'(1 << OP_BLTU), 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        run_one("bge",  16'(1 << OP_BGE),  32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        run_one("bgeu", 16'(1 << OP_BGEU), 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        run_one("beq",  16'(1 << OP_BEQ),  32'h1234_5678, 32'h1234_5678, 32'd0, 1'b0);
        run_one("bne",  16'(1 << OP_BNE),  32'h1234_5678, 32'h1234_5678, 32'd0, 1'b0);
    endtask

    task automatic test_corners;
        run_one("imm_add", 16'(1 << OP_ADD), 32'h10, 32'h99, 32'h20, 1'b1);
        run_one("no_op",   16'h0000,         32'h55, 32'h66, 32'd0, 1'b0);
        run_one("add_sub", 16'((1 << OP_ADD) | (1 << OP_SUB)), 32'd9, 32'd4, 32'd0, 1'b0);
        run_one("sll_and_add", 16'((1 << OP_SLL) | (1 << OP_ADD)), 32'd9, 32'd4, 32'd0, 1'b0);
    endtask

    task automatic test_random;
        logic [15:0] v;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) v = 16'($urandom);
            else v = 16'(1 << $urandom_range(0, 15));
            run_one("rand", v, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_shift();
        test_back_to_back();
        @(negedge clk);
        test_shifts();
        test_start_during_busy();
        @(negedge clk);
        test_branches();
        test_corners();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rv32i_alu_mc.md
Name: rv32i_alu_mc

Overview:
- Multi-cycle RV32I ALU for the MCU datapath. It executes the one-hot operation vector produced by the ALU decoder.
- Add, sub, compare, logic and branch ops complete in one cycle. Shifts run serially, one bit per cycle, to save area.
- A start/done handshake lets the control FSM stall the core while a shift is in progress.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- SHW, 5, shift-amount width; equals log2(XLEN).

Ports:
- clk_i  in  1  system clock, rising edge
- rst_i  in  1  asynchronous reset, active-high
- start_i  in  1  request: latch operands and op vector this cycle
- op_add_i, op_sub_i, op_sll_i, op_slt_i, op_sltu_i, op_xor_i, op_srl_i, op_sra_i, op_or_i, op_and_i  in  1 each  one-hot arithmetic/logic op select
- op_beq_i, op_bne_i, op_blt_i, op_bge_i, op_bltu_i, op_bgeu_i  in  1 each  one-hot branch compare select
- op_rs2_imm_i  in  1  1: operand B = imm_i; 0: operand B = rs2_i
- rs1_i  in  XLEN  operand A
- rs2_i  in  XLEN  operand B (register)
- imm_i  in  XLEN  operand B (immediate)
- busy_o  out  1  high while a serial shift is executing
- done_o  out  1  one-cycle pulse: result_o/br_taken_o valid
- result_o  out  XLEN  operation result; held until the next accepted start
- br_taken_o  out  1  branch condition result; held with result_o

Behaviour:
- Reset (asynchronous, any state including mid-shift):
  - state = IDLE.
  - busy_o = 0, done_o = 0, result_o = 0, br_taken_o = 0.
  - Shift counter and operand registers cleared.
- States: IDLE, SHIFT, DONE.
- Accept rule: start_i is accepted only in IDLE or DONE. start_i during SHIFT is ignored and not queued.
- On accept:
  - Latch A = rs1_i and B = (op_rs2_imm_i ? imm_i : rs2_i), plus all op inputs.
  - Shift op with B[4:0] != 0: go to SHIFT with counter = B[4:0] and working register = A.
  - Any other case: compute the result combinationally from the latched-at-accept values, register it, and go to DONE.
- Latency (start cycle = 0):
  - Non-shift ops, and shifts with amount 0: done_o at cycle 1.
  - Shift by n (1..31): done_o at cycle n+1.
- SHIFT state:
  - busy_o = 1.
  - Each cycle the working register shifts one bit. SLL fills with 0; SRL fills with 0; SRA replicates bit 31.
  - Counter decrements each cycle. When the counter is 1, do the final shift, load result_o, and go to DONE.
- DONE state:
  - done_o = 1 for exactly one cycle.
  - Next state is SHIFT if a new shift start is accepted with nonzero amount. It stays DONE (new result) if any other start is accepted. Otherwise it goes to IDLE.
  - Back-to-back starts therefore give done_o every cycle for single-cycle ops.
- Arithmetic rules:
  - Add/sub wrap modulo 2^32.
  - SLT is signed and SLTU unsigned; both return 32'd1 or 32'd0.
  - Shift amount uses B[4:0] only; B[31:5] are ignored.
- Branch ops:
  - result_o = 0.
  - br_taken_o compares A against B, with signed compare for BLT/BGE and unsigned for BLTU/BGEU.
  - For non-branch ops, br_taken_o = 0.
- Op-vector rules:
  - All op inputs zero on accept: result_o = 0, br_taken_o = 0, latency 1.
  - More than one op set: the first set op in port-list order wins (add highest). This is deterministic, not an error.
- Output hold: result_o and br_taken_o change only on completion of an accepted op or on reset, never during SHIFT.

Test Plan:
1. Reset mid-shift: start SRA with A=0x80000000, B=31; assert rst_i at cycle 5 -> busy_o, done_o and result_o go to 0 immediately (asynchronously); next start ADD 2+3 -> result 5, done_o at cycle 1.
2. Single-cycle ops back-to-back on consecutive cycles:
   - ADD 0xFFFFFFFF+1 -> 0x0.
   - SUB 0-1 -> 0xFFFFFFFF.
   - SLT 0xFFFFFFFF,1 -> 1.
   - SLTU 0xFFFFFFFF,1 -> 0.
   - done_o high 4 consecutive cycles.
3. Shifts:
   - SLL 0x1 by 31 -> 0x80000000, done_o at cycle 32, busy_o high cycles 1..31.
   - SRA 0x80000000 by 4 -> 0xF8000000.
   - SRL 0x80000000 by 4 -> 0x08000000.
   - Shift by 0 (B=0x20) -> result = A, done_o at cycle 1.
4. Start during busy: SRL by 10, pulse start_i (ADD) at cycle 3 -> ignored; result is the SRL value at cycle 11; no extra done_o.
5. Branches with A=0xFFFFFFFF, B=0x1:
   - BLT -> br_taken 1; BLTU -> 0; BGE -> 0; BGEU -> 1.
   - BEQ with A=B -> 1; BNE with A=B -> 0.
   - result_o = 0 for all.
6. Operand mux and op-vector corners:
   - op_rs2_imm_i=1, ADD rs1=0x10, imm=0x20, rs2=0x99 -> 0x30.
   - All ops zero -> result 0.
   - ADD and SUB both set -> ADD result.
